shift_alu_sequencer: RTL and testbench

SHIFT_ALU_SEQUENCER -- requirements
Module: shift_alu_sequencer

---
 rtl/shift_alu_sequencer.sv | 134 +++++++++++++
 tb/tb_shift_alu_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/shift_alu_sequencer.sv
// shift_alu_sequencer: Moore control sequencer (fetch T0-T3, decode/execute T4-T6) for a shift/ALU datapath
// Ports:
//   clock, clear (async active-low reset), run (start/continue), mem_ready (memory read complete)
//   ir[31:0]: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//   PCout..Yin: datapath strobes; R_in/R_out: one-hot register enables; alu_op: ALU opcode
//   done/illegal: one-cycle retire/skip pulses; halted: high while in HALT
module shift_alu_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        Zin,
    output logic        Zlo_out,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic [15:0] R_in,
    output logic [15:0] R_out,
    output logic [4:0]  alu_op,
    output logic        done,
    output logic        illegal,
    output logic        halted
);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
    state_t state, nxt;
    logic [4:0] op;
    logic legal, halt_op, unused_ir;
    assign op        = ir[31:27];
    assign legal     = op <= 5'd8;
    assign halt_op   = op == 5'd27;
    assign unused_ir = ^ir[14:0];
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = run ? T0 : IDLE;
            T0:      nxt = T1;
            T1:      nxt = T2;
            T2:      nxt = mem_ready ? T3 : T2;
            T3:      nxt = T4;
            T4:      nxt = legal ? T5 : halt_op ? HALT : run ? T0 : IDLE;
            T5:      nxt = T6;
            T6:      nxt = run ? T0 : IDLE;
            HALT:    nxt = HALT;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            PCout   <= 1'b0;
            IncPC   <= 1'b0;
            MARin   <= 1'b0;
            Zin     <= 1'b0;
            Zlo_out <= 1'b0;
            PCin    <= 1'b0;
            Read    <= 1'b0;
            MDRin   <= 1'b0;
            MDRout  <= 1'b0;
            IRin    <= 1'b0;
            Yin     <= 1'b0;
            R_in    <= '0;
            R_out   <= '0;
            alu_op  <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= nxt;
            PCout   <= 1'b0;
            IncPC   <= 1'b0;
            MARin   <= 1'b0;
            Zin     <= 1'b0;
            Zlo_out <= 1'b0;
            PCin    <= 1'b0;
            Read    <= 1'b0;
            MDRin   <= 1'b0;
            MDRout  <= 1'b0;
            IRin    <= 1'b0;
            Yin     <= 1'b0;
            R_in    <= '0;
            R_out   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            halted  <= 1'b0;
            case (nxt)
                T0: begin
                    PCout <= 1'b1;
                    MARin <= 1'b1;
                    IncPC <= 1'b1;
                    Zin   <= 1'b1;
                end
                T1: begin
                    Zlo_out <= 1'b1;
                    PCin    <= 1'b1;
                end
                T2: begin
                    Read  <= 1'b1;
                    MDRin <= 1'b1;
                end
                T3: begin
                    MDRout <= 1'b1;
                    IRin   <= 1'b1;
                end
                // The halt opcode enters T4 with every strobe low.
                T4: begin
                    R_out   <= legal ? 16'd1 << ir[22:19] : 16'd0;
                    Yin     <= legal;
                    illegal <= !legal && !halt_op;
                end
                T5: begin
                    R_out  <= 16'd1 << ir[18:15];
                    Zin    <= 1'b1;
                    alu_op <= op;
                end
                // R0 is never written; the instruction still retires.
                T6: begin
                    Zlo_out <= 1'b1;
                    R_in    <= (ir[26:23] == 4'd0) ? 16'd0 : 16'd1 << ir[26:23];
                    done    <= 1'b1;
                end
                HALT:    halted <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_alu_sequencer.sv
// tb_shift_alu_sequencer: directed and randomized instruction traces checked against a per-instruction expected-trace model
module tb_shift_alu_sequencer;
    logic clock = 1'b0;
    logic clear, run, mem_ready;
    logic [31:0] ir;
    logic PCout, IncPC, MARin, Zin, Zlo_out, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic [15:0] R_in, R_out;
    logic [4:0] alu_op;
    logic done, illegal, halted;

    shift_alu_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlo_out(Zlo_out),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .R_in(R_in), .R_out(R_out), .alu_op(alu_op), .done(done), .illegal(illegal),
        .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic pc_out, inc_pc, mar_in, z_in, zlo_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
        logic [15:0] r_in, r_out;
        logic [4:0] alu;
        logic done, illegal, halted;
    } exp_t;

    int checks = 0;
    int failures = 0;
    logic [4:0] last_alu = 5'd0;
    exp_t q[$];

    function automatic exp_t obs();
        return {PCout, IncPC, MARin, Zin, Zlo_out, PCin, Read, MDRin, MDRout, IRin, Yin,
                R_in, R_out, alu_op, done, illegal, halted};
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e = '0;
        e.alu = last_alu;
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e);
        exp_t o;
        logic inv;
        o = obs();
        inv = $onehot0(R_in) && $onehot0(R_out) && ($countones({PCout, Zlo_out, MDRout, R_out}) <= 1);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
        checks++;
        assert (inv === 1'b1) else begin
            failures++;
            $error("FAIL %s_onehot: observed R_in=%h R_out=%h drivers=%b expected single/none", tag, R_in, R_out,
                   {PCout, Zlo_out, MDRout, |R_out});
        end
    endtask

    // Precondition: called just after a negedge with inputs set so the next rising edge enters T0.
    task automatic do_instr(input logic [31:0] instr, input int waits, input logic run_next, input int abort_at);
        exp_t e;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        logic legal, hlt;
        int n;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        legal = op <= 5'd8;
        hlt = op == 5'd27;
        q.delete();
        e = blank(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; q.push_back(e);
        e = blank(); e.zlo_out = 1; e.pc_in = 1; q.push_back(e);
        for (int i = 0; i <= waits; i++) begin
            e = blank(); e.read = 1; e.mdr_in = 1; q.push_back(e);
        end
        e = blank(); e.mdr_out = 1; e.ir_in = 1; q.push_back(e);
        e = blank();
        if (legal) begin
            e.r_out = 16'd1 << rb;
            e.y_in = 1;
        end else if (!hlt) e.illegal = 1;
        q.push_back(e);
        if (legal) begin
            e = blank(); e.r_out = 16'd1 << rc; e.z_in = 1; e.alu = op; q.push_back(e);
            e = blank(); e.alu = op; e.zlo_out = 1; e.r_in = (ra == 4'd0) ? 16'd0 : 16'd1 << ra; e.done = 1;
            q.push_back(e);
            last_alu = op;
        end
        if (hlt) begin
            e = blank(); e.halted = 1; q.push_back(e);
        end
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("i%h_c%0d", instr, i), q[i]);
            if (i == abort_at) begin
                #2 clear = 1'b0;
                #1 last_alu = 5'd0;
                check("clear_async", blank());
                return;
            end
            mem_ready = (i >= 2 && i <= 2 + waits) ? (i == 2 + waits) : 1'($urandom);
            ir = (i >= 3 + waits && i <= 5 + waits) ? instr : $urandom;
            run = (i == n - 1) ? run_next : 1'($urandom);
        end
    endtask

    task automatic idle(input int n, input logic run_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("idle", blank());
            run = (i == n - 1) ? run_last : 1'b0;
            ir = $urandom;
            mem_ready = 1'($urandom);
        end
    endtask

    initial begin
        logic [4:0] op;
        logic [31:0] instr;
        logic rn;
        clear = 1'b0;
        run = 1'b1;
        mem_ready = 1'b1;
        ir = $urandom;
        repeat (3) begin
            @(negedge clock);
            check("reset", blank());
        end
        clear = 1'b1;
        do_instr(32'h2891_8000, 0, 1'b1, -1);
        do_instr(32'h3091_8000, 0, 1'b1, -1);
        do_instr(32'h3891_8000, 0, 1'b1, -1);
        do_instr(32'h2891_8000, 3, 1'b0, -1);
        idle(2, 1'b1);
        do_instr(32'hA891_8000, 0, 1'b1, -1);
        do_instr({5'd0, 4'd0, 4'd2, 4'd3, 15'd0}, 1, 1'b1, -1);
        do_instr(32'h3891_8000, 0, 1'b1, 5);
        @(posedge clock);
        @(negedge clock);
        check("clear_hold", blank());
        clear = 1'b1;
        run = 1'b0;
        idle(2, 1'b1);
        for (int k = 0; k < 40; k++) begin
            op = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 8)) : 5'($urandom_range(9, 31));
            if (op == 5'd27) op = 5'd9;
            instr = {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
            rn = $urandom_range(0, 3) != 0;
            do_instr(instr, $urandom_range(0, 3), rn, -1);
            if (!rn) idle($urandom_range(1, 3), 1'b1);
        end
        do_instr(32'hD800_0000, 1, 1'b1, -1);
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
            e_halt: check("halt", '{default: 0, alu: last_alu, halted: 1'b1});
            run = 1'b1;
            ir = $urandom;
            mem_ready = 1'($urandom);
        end
        #2 clear = 1'b0;
        #1 last_alu = 5'd0;
        check("halt_clear", blank());
        @(negedge clock);
        clear = 1'b1;
        run = 1'b0;
        idle(2, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
